pc_seq: RTL and testbench

//  Registered program-counter sequencer for the fetch stage; successor to the combinational PC-next logic.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_seq_if.sv | 34 +++
 rtl/pc_seq_ras.sv | 57 +++++
 rtl/pc_seq.sv | 164 ++++++++++++++++
 tb/tb_pc_seq.sv | 139 +++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
//   pc_mode_e  : next-PC command presented each cycle by the fetch controller
//   pc_cause_e : reason recorded on trap entry
package pc_pkg;

    typedef enum logic [2:0] {
        ModeStall  = 3'd0,
        ModeNext   = 3'd1,
        ModeBrRel  = 3'd2,
        ModeJmpAbs = 3'd3,
        ModeCall   = 3'd4,
        ModeRet    = 3'd5,
        ModeTrap   = 3'd6,
        ModeEret   = 3'd7
    } pc_mode_e;

    typedef enum logic [1:0] {
        CauseSw           = 2'd0,
        CauseMisalign     = 2'd1,
        CauseRasUnderflow = 2'd2,
        CauseRsvd         = 2'd3
    } pc_cause_e;

endpackage

// File: rtl/pc_seq_if.sv
// Command/status bundle between the fetch controller and pc_seq.
//   i_mode/i_target : next-PC command (driven by master)
//   o_pc, o_epc     : current PC and PC saved on last trap entry
//   o_cause         : cause of last trap
//   o_in_trap       : trap handler active
//   o_ras_count     : valid return-address stack entries
//   o_dbl_fault     : one-cycle pulse on a trap request while already in a trap
interface pc_seq_if
    import pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    pc_mode_e         i_mode;
    logic [31:0]      i_target;
    logic [31:0]      o_pc;
    logic [31:0]      o_epc;
    logic [1:0]       o_cause;
    logic             o_in_trap;
    logic [CNT_W-1:0] o_ras_count;
    logic             o_dbl_fault;

    modport master (
        output i_mode, i_target,
        input  o_pc, o_epc, o_cause, o_in_trap, o_ras_count, o_dbl_fault
    );

    modport slave (
        input  i_mode, i_target,
        output o_pc, o_epc, o_cause, o_in_trap, o_ras_count, o_dbl_fault
    );

endinterface

// File: rtl/pc_seq_ras.sv
// pc_ras: circular return-address stack.
//   i_clk, i_reset : clock, synchronous active-high reset (clears all entries)
//   i_push, i_data : push i_data; when full the oldest entry is overwritten
//   i_pop          : discard top entry (ignored when empty)
//   o_top          : current top entry (valid when o_count != 0)
//   o_count        : number of valid entries, saturates at RAS_DEPTH
// Push and pop are never requested together by the sequencer; push wins if they are.
module pc_ras #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned W         = 13
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] o_count
);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [W-1:0]     mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;        // next slot to write
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    // Explicit wrap so non-power-of-two depths stay circular.
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    end

    assign o_top   = mem_q[ptr_dec];
    assign o_count = count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_push) begin
            mem_q[ptr_q] <= i_data;
            ptr_q        <= ptr_inc;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (i_pop && (count_q != '0)) begin
            ptr_q   <= ptr_dec;
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: registered program-counter sequencer for the fetch stage.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : i_mode/i_target command in; o_pc, o_epc, o_cause, o_in_trap,
//                    o_ras_count, o_dbl_fault status out
// The PC lives in a byte-address field wide enough to span the instruction memory
// (MEM_DEPTH halfwords) and wraps modulo its size; upper o_pc bits read as zero.
// Targets with bit 0 set and returns from an empty RAS become traps; any trap
// request while already in a trap only pulses o_dbl_fault.
module pc_seq
    import pc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned INC       = 2,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned TRAP_VEC  = 'h10,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_reset,
    pc_seq_if.slave  bus
);
    // Byte address field covering MEM_DEPTH halfwords: pc = o_pc[ADDR_WIDTH:0].
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH * 2) - 1;
    localparam int unsigned W          = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W      = $clog2(RAS_DEPTH + 1);

    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] epc_q, epc_d;
    pc_cause_e    cause_q, cause_d;
    logic         in_trap_q, in_trap_d;
    logic         dbl_q, dbl_d;

    logic [W-1:0]     tgt;
    logic [W-1:0]     pc_seq_nxt;
    logic [W-1:0]     pc_rel;
    logic [W-1:0]     ras_top;
    logic [CNT_W-1:0] ras_count;
    logic             ras_push;
    logic             ras_pop;
    logic             trap_req;
    pc_cause_e        trap_cause;

    // Offsets and absolute targets are truncated to the PC field before use.
    assign tgt        = bus.i_target[W-1:0];
    assign pc_seq_nxt = pc_q + W'(INC);
    assign pc_rel     = pc_q + tgt;

    logic unused_target_hi;
    assign unused_target_hi = ^bus.i_target[31:W];

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .W         (W)
    ) u_ras (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (ras_push),
        .i_pop   (ras_pop),
        .i_data  (pc_seq_nxt),
        .o_top   (ras_top),
        .o_count (ras_count)
    );

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        in_trap_d  = in_trap_q;
        dbl_d      = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        trap_req   = 1'b0;
        trap_cause = CauseSw;

        unique case (bus.i_mode)
            ModeStall: ;
            ModeNext:  pc_d = pc_seq_nxt;
            ModeBrRel: begin
                if (pc_rel[0]) begin
                    trap_req   = 1'b1;
                    trap_cause = CauseMisalign;
                end else begin
                    pc_d = pc_rel;
                end
            end
            ModeJmpAbs: begin
                if (tgt[0]) begin
                    trap_req   = 1'b1;
                    trap_cause = CauseMisalign;
                end else begin
                    pc_d = tgt;
                end
            end
            ModeCall: begin
                if (pc_rel[0]) begin
                    trap_req   = 1'b1;
                    trap_cause = CauseMisalign;
                end else begin
                    pc_d     = pc_rel;
                    ras_push = 1'b1;
                end
            end
            ModeRet: begin
                if (ras_count == '0) begin
                    trap_req   = 1'b1;
                    trap_cause = CauseRasUnderflow;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end
            ModeTrap: begin
                trap_req   = 1'b1;
                trap_cause = CauseSw;
            end
            ModeEret: begin
                if (in_trap_q) begin
                    pc_d      = epc_q;
                    in_trap_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Trap entry overrides the mode result; a nested request freezes everything.
        if (trap_req) begin
            ras_push = 1'b0;
            ras_pop  = 1'b0;
            if (in_trap_q) begin
                pc_d  = pc_q;
                dbl_d = 1'b1;
            end else begin
                epc_d     = pc_q;
                cause_d   = trap_cause;
                pc_d      = W'(TRAP_VEC);
                in_trap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q      <= W'(RESET_PC);
            epc_q     <= '0;
            cause_q   <= CauseSw;
            in_trap_q <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            in_trap_q <= in_trap_d;
            dbl_q     <= dbl_d;
        end
    end

    assign bus.o_pc        = {{(32 - W){1'b0}}, pc_q};
    assign bus.o_epc       = {{(32 - W){1'b0}}, epc_q};
    assign bus.o_cause     = cause_q;
    assign bus.o_in_trap   = in_trap_q;
    assign bus.o_ras_count = ras_count;
    assign bus.o_dbl_fault = dbl_q;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;
    import pc_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        in_trap;
        logic [2:0]  cnt;
        logic        dbl;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   tests;
    int   fails;

    pc_seq_if #(.RAS_DEPTH(4)) bus ();

    pc_seq #(
        .MEM_DEPTH (4096),
        .INC       (2),
        .RESET_PC  (0),
        .TRAP_VEC  ('h10),
        .RAS_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one command at the falling edge and queue the state expected after the next rise.
    task automatic step(input logic r, input pc_mode_e m, input logic [31:0] t, input string nm,
                        input logic [31:0] pc, input logic [31:0] epc, input logic [1:0] cause,
                        input logic it, input logic [2:0] cnt, input logic dbl);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.i_mode   = m;
        bus.i_target = t;
        e.name = nm; e.pc = pc; e.epc = epc; e.cause = cause;
        e.in_trap = it; e.cnt = cnt; e.dbl = dbl;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with an outstanding expectation, compare outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.o_pc !== e.pc || bus.o_epc !== e.epc || bus.o_cause !== e.cause ||
                    bus.o_in_trap !== e.in_trap || bus.o_ras_count !== e.cnt ||
                    bus.o_dbl_fault !== e.dbl) begin
                    fails++;
                    $display("FAIL %s: got pc=%h epc=%h cause=%0d trap=%b cnt=%0d dbl=%b; want pc=%h epc=%h cause=%0d trap=%b cnt=%0d dbl=%b",
                             e.name, bus.o_pc, bus.o_epc, bus.o_cause, bus.o_in_trap,
                             bus.o_ras_count, bus.o_dbl_fault, e.pc, e.epc, e.cause,
                             e.in_trap, e.cnt, e.dbl);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.i_mode = ModeStall;
        bus.i_target = '0;

        //   rst   mode        target        name            pc       epc      ca it cnt dbl
        // 1. reset overrides mode, sequential step, stall
        step(1'b1, ModeNext,   32'h55,       "reset",        32'h0,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next0",        32'h2,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next1",        32'h4,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next2",        32'h6,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeStall,  32'hdead,     "stall0",       32'h6,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeStall,  32'h0,        "stall1",       32'h6,   32'h0,   0, 0, 0, 0);
        // 2. branches and misaligned jump
        step(1'b0, ModeBrRel,  32'hFFFFFFFC, "br_rel_neg",   32'h2,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeJmpAbs, 32'h100,      "jmp_abs",      32'h100, 32'h0,   0, 0, 0, 0);
        step(1'b0, ModeJmpAbs, 32'h101,      "jmp_misalign", 32'h10,  32'h100, 1, 1, 0, 0);
        // 3. wrap of the 13-bit PC field
        step(1'b1, ModeStall,  32'h0,        "reset2",       32'h0,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeJmpAbs, 32'h1FFE,     "jmp_top",      32'h1FFE,32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next_wrap",    32'h0,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next_a",       32'h2,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeNext,   32'h0,        "next_b",       32'h4,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeBrRel,  32'hFFFFE000, "br_full_wrap", 32'h4,   32'h0,   0, 0, 0, 0);
        // 4. RAS fill, overwrite of oldest, drain, underflow
        step(1'b1, ModeStall,  32'h0,        "reset3",       32'h0,   32'h0,   0, 0, 0, 0);
        step(1'b0, ModeCall,   32'h10,       "call0",        32'h10,  32'h0,   0, 0, 1, 0);
        step(1'b0, ModeCall,   32'h10,       "call1",        32'h20,  32'h0,   0, 0, 2, 0);
        step(1'b0, ModeCall,   32'h10,       "call2",        32'h30,  32'h0,   0, 0, 3, 0);
        step(1'b0, ModeCall,   32'h10,       "call3",        32'h40,  32'h0,   0, 0, 4, 0);
        step(1'b0, ModeCall,   32'h10,       "call4_full",   32'h50,  32'h0,   0, 0, 4, 0);
        step(1'b0, ModeRet,    32'h0,        "ret0",         32'h42,  32'h0,   0, 0, 3, 0);
        step(1'b0, ModeRet,    32'h0,        "ret1",         32'h32,  32'h0,   0, 0, 2, 0);
        step(1'b0, ModeRet,    32'h0,        "ret2",         32'h22,  32'h0,   0, 0, 1, 0);
        step(1'b0, ModeRet,    32'h0,        "ret3",         32'h12,  32'h0,   0, 0, 0, 0);
        step(1'b0, ModeRet,    32'h0,        "ret_underflow",32'h10,  32'h12,  2, 1, 0, 0);
        // 5. software trap, double fault, trap return
        step(1'b0, ModeEret,   32'h0,        "eret_clear",   32'h12,  32'h12,  2, 0, 0, 0);
        step(1'b0, ModeJmpAbs, 32'h40,       "jmp_40",       32'h40,  32'h12,  2, 0, 0, 0);
        step(1'b0, ModeTrap,   32'h0,        "trap_sw",      32'h10,  32'h40,  0, 1, 0, 0);
        step(1'b0, ModeTrap,   32'h0,        "trap_double",  32'h10,  32'h40,  0, 1, 0, 1);
        step(1'b0, ModeStall,  32'h0,        "dbl_pulse_end",32'h10,  32'h40,  0, 1, 0, 0);
        step(1'b0, ModeEret,   32'h0,        "eret",         32'h40,  32'h40,  0, 0, 0, 0);
        step(1'b0, ModeEret,   32'h0,        "eret_idle",    32'h40,  32'h40,  0, 0, 0, 0);
        // 6. RAS survives traps; internal fault in a trap; reset mid-sequence
        step(1'b0, ModeCall,   32'h10,       "call_a",       32'h50,  32'h40,  0, 0, 1, 0);
        step(1'b0, ModeCall,   32'h10,       "call_b",       32'h60,  32'h40,  0, 0, 2, 0);
        step(1'b0, ModeCall,   32'h10,       "call_c",       32'h70,  32'h40,  0, 0, 3, 0);
        step(1'b0, ModeTrap,   32'h0,        "trap_keep_ras",32'h10,  32'h70,  0, 1, 3, 0);
        step(1'b0, ModeCall,   32'h11,       "misalign_dbl", 32'h10,  32'h70,  0, 1, 3, 1);
        step(1'b1, ModeNext,   32'h0,        "reset_mid",    32'h0,   32'h0,   0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        bus.i_mode = ModeStall;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
